// File: rtl/core_sequencer.sv
// Program sequencer: fetches from instruction memory, follows jump-table redirects
// and ends a run on timeout, a run of all-zero instructions, or the top of the PC space.
module core_sequencer #(
    parameter  int PC_W       = 8,
    parameter  int IW         = 9,
    parameter  int LUT_DEPTH  = 32,
    parameter  int HALT_ZEROS = 2,
    parameter  int MAX_CYCLES = 0,
    localparam int LW         = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    output logic [PC_W-1:0] o_imem_addr,
    input  logic [IW-1:0]   i_imem_data,
    input  logic            i_branch_taken,
    input  logic [LW-1:0]   i_branch_idx,
    input  logic            i_stall,
    input  logic            i_lut_wr_en,
    input  logic [LW-1:0]   i_lut_wr_idx,
    input  logic [PC_W-1:0] i_lut_wr_data,
    output logic            o_run,
    output logic            o_done,
    output logic            o_timeout,
    output logic [31:0]     o_cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_ZERO  = PC_W'(0);
    localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);
    localparam logic [PC_W-1:0] PC_LAST  = {PC_W{1'b1}};
    localparam logic [31:0]     CYC_MAX  = 32'hFFFF_FFFF;
    localparam logic [31:0]     CYC_END  = 32'(MAX_CYCLES - 1);
    localparam logic [3:0]      HALT_CNT = 4'(HALT_ZEROS);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_cyc;
    logic [3:0]      r_zc;
    logic            r_timeout;
    logic            r_run;
    logic            r_done;
    logic [PC_W-1:0] r_lut [LUT_DEPTH];

    state_t          w_state_nxt;
    logic [PC_W-1:0] w_pc_nxt;
    logic [31:0]     w_cyc_nxt;
    logic [3:0]      w_zc_nxt;
    logic            w_timeout_nxt;
    logic            w_zero;
    logic [3:0]      w_zc_inc;
    logic            w_hit_timeout;
    logic [PC_W-1:0] w_target;

    assign w_zero        = (i_imem_data == {IW{1'b0}});
    assign w_zc_inc      = r_zc + 4'd1;
    assign w_hit_timeout = (MAX_CYCLES != 0) && (r_cyc == CYC_END);
    // Table read sees the pre-edge contents, so a same-cycle write is not forwarded.
    assign w_target      = r_lut[i_branch_idx];

    // Next-state, PC, counters and timeout flag.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_cyc_nxt     = r_cyc;
        w_zc_nxt      = r_zc;
        w_timeout_nxt = r_timeout;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nxt   = S_RUN;
                    w_pc_nxt      = PC_ZERO;
                    w_cyc_nxt     = 32'd0;
                    w_zc_nxt      = 4'd0;
                    w_timeout_nxt = 1'b0;
                end else begin
                    w_state_nxt   = r_state;
                end
            end
            S_RUN: begin
                w_cyc_nxt = (r_cyc == CYC_MAX) ? CYC_MAX : r_cyc + 32'd1;
                if (w_hit_timeout) begin
                    w_state_nxt   = S_DONE;
                    w_timeout_nxt = 1'b1;
                end else if (!i_stall && w_zero && (w_zc_inc == HALT_CNT)) begin
                    w_state_nxt = S_DONE;
                end else if (!i_stall && !i_branch_taken && (r_pc == PC_LAST)) begin
                    w_state_nxt = S_DONE;
                end else if (!i_stall) begin
                    w_pc_nxt = i_branch_taken ? w_target : r_pc + PC_ONE;
                    w_zc_nxt = w_zero ? w_zc_inc : 4'd0;
                end else begin
                    w_pc_nxt = r_pc;
                    w_zc_nxt = r_zc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_pc      <= PC_ZERO;
            r_cyc     <= 32'd0;
            r_zc      <= 4'd0;
            r_timeout <= 1'b0;
            r_run     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_cyc     <= w_cyc_nxt;
            r_zc      <= w_zc_nxt;
            r_timeout <= w_timeout_nxt;
            r_run     <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    // Jump table: writable in any state, cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_lut[i] <= PC_ZERO;
            end
        end else if (i_lut_wr_en) begin
            r_lut[i_lut_wr_idx] <= i_lut_wr_data;
        end else begin
            r_lut[i_lut_wr_idx] <= r_lut[i_lut_wr_idx];
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_run         = r_run;
    assign o_done        = r_done;
    assign o_timeout     = r_timeout;
    assign o_cycle_count = r_cyc;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: MAX_CYCLES=10, HALT_ZEROS=2, PC_W=8.
module tb_core_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  imem_addr;
    logic [8:0]  imem_data;
    logic        branch_taken;
    logic [4:0]  branch_idx;
    logic        stall;
    logic        lut_wr_en;
    logic [4:0]  lut_wr_idx;
    logic [7:0]  lut_wr_data;
    logic        run;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;

    logic [8:0]  mem [256];
    int          total;
    int          bad;

    core_sequencer #(
        .PC_W(8), .IW(9), .LUT_DEPTH(32), .HALT_ZEROS(2), .MAX_CYCLES(10)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .o_imem_addr(imem_addr), .i_imem_data(imem_data),
        .i_branch_taken(branch_taken), .i_branch_idx(branch_idx), .i_stall(stall),
        .i_lut_wr_en(lut_wr_en), .i_lut_wr_idx(lut_wr_idx), .i_lut_wr_data(lut_wr_data),
        .o_run(run), .o_done(done), .o_timeout(timeout), .o_cycle_count(cycle_count)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic lut_write(input logic [4:0] idx, input logic [7:0] d);
        lut_wr_en = 1'b1; lut_wr_idx = idx; lut_wr_data = d;
        tick();
        lut_wr_en = 1'b0;
    endtask

    task automatic branch_to(input logic [4:0] idx);
        branch_taken = 1'b1; branch_idx = idx;
        tick();
        branch_taken = 1'b0;
    endtask

    task automatic finish_run;
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL finish_run done=%b want=1", done); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h want=00", imem_addr); end
        total++; if (run !== 1'b0) begin bad++; $display("FAIL reset_run got=%b want=0", run); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL reset_cyc got=%0d want=0", cycle_count); end
        tick();
        total++; if (run !== 1'b0) begin bad++; $display("FAIL idle_hold run=%b want=0", run); end
    endtask

    task automatic test_branch;
        lut_write(5'd3, 8'h20);
        do_start();
        total++; if (run !== 1'b1 || imem_addr !== 8'h00) begin bad++; $display("FAIL start_run run=%b pc=%h want 1/00", run, imem_addr); end
        repeat (5) tick();
        total++; if (imem_addr !== 8'h05) begin bad++; $display("FAIL br_pre got=%h want=05", imem_addr); end
        branch_to(5'd3);
        total++; if (imem_addr !== 8'h20) begin bad++; $display("FAIL br_target got=%h want=20", imem_addr); end
        tick();
        total++; if (imem_addr !== 8'h21) begin bad++; $display("FAIL br_next got=%h want=21", imem_addr); end
        finish_run();
    endtask

    task automatic test_timeout;
        do_start();
        total++; if (timeout !== 1'b0 || cycle_count !== 32'd0) begin bad++; $display("FAIL to_clear to=%b cyc=%0d want 0/0", timeout, cycle_count); end
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (imem_addr !== 8'h04 || run !== 1'b1) begin bad++; $display("FAIL start_in_run pc=%h run=%b want 04/1", imem_addr, run); end
        repeat (5) tick();
        total++; if (done !== 1'b0 || cycle_count !== 32'd9) begin bad++; $display("FAIL to_early done=%b cyc=%0d want 0/9", done, cycle_count); end
        tick();
        total++; if (done !== 1'b1 || timeout !== 1'b1) begin bad++; $display("FAIL to_end done=%b to=%b want 1/1", done, timeout); end
        total++; if (cycle_count !== 32'd10 || imem_addr !== 8'h09 || run !== 1'b0) begin bad++; $display("FAIL to_freeze cyc=%0d pc=%h run=%b want 10/09/0", cycle_count, imem_addr, run); end
        repeat (3) tick();
        total++; if (done !== 1'b1 || cycle_count !== 32'd10) begin bad++; $display("FAIL done_hold done=%b cyc=%0d want 1/10", done, cycle_count); end
    endtask

    task automatic test_halt;
        mem[2] = 9'h000; mem[6] = 9'h000; mem[7] = 9'h000;
        do_start();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL halt_to_clear got=%b want=0", timeout); end
        repeat (7) tick();
        total++; if (done !== 1'b0 || imem_addr !== 8'h07) begin bad++; $display("FAIL halt_early done=%b pc=%h want 0/07", done, imem_addr); end
        tick();
        total++; if (done !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL halt_end done=%b to=%b want 1/0", done, timeout); end
        total++; if (cycle_count !== 32'd8 || imem_addr !== 8'h07) begin bad++; $display("FAIL halt_freeze cyc=%0d pc=%h want 8/07", cycle_count, imem_addr); end
        mem[2] = 9'h001; mem[6] = 9'h001; mem[7] = 9'h001;
    endtask

    task automatic test_stall;
        mem[4] = 9'h000; mem[5] = 9'h000;
        do_start();
        repeat (4) tick();
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        total++; if (imem_addr !== 8'h04 || cycle_count !== 32'd7 || done !== 1'b0) begin bad++; $display("FAIL stall_hold pc=%h cyc=%0d done=%b want 04/7/0", imem_addr, cycle_count, done); end
        tick();
        total++; if (imem_addr !== 8'h05 || done !== 1'b0 || cycle_count !== 32'd8) begin bad++; $display("FAIL stall_release pc=%h done=%b cyc=%0d want 05/0/8", imem_addr, done, cycle_count); end
        tick();
        total++; if (done !== 1'b1 || imem_addr !== 8'h05 || cycle_count !== 32'd9) begin bad++; $display("FAIL stall_halt done=%b pc=%h cyc=%0d want 1/05/9", done, imem_addr, cycle_count); end
        mem[4] = 9'h001; mem[5] = 9'h001;
    endtask

    task automatic test_wrap_end;
        lut_write(5'd5, 8'hFE);
        lut_write(5'd6, 8'h30);
        do_start();
        repeat (5) tick();
        branch_to(5'd5);
        total++; if (imem_addr !== 8'hFE) begin bad++; $display("FAIL wrap_br got=%h want=fe", imem_addr); end
        tick();
        total++; if (imem_addr !== 8'hFF) begin bad++; $display("FAIL wrap_top got=%h want=ff", imem_addr); end
        tick();
        total++; if (done !== 1'b1 || imem_addr !== 8'hFF || cycle_count !== 32'd8 || timeout !== 1'b0) begin bad++; $display("FAIL top_end done=%b pc=%h cyc=%0d to=%b want 1/ff/8/0", done, imem_addr, cycle_count, timeout); end
        do_start();
        repeat (5) tick();
        branch_to(5'd5);
        tick();
        branch_to(5'd6);
        total++; if (imem_addr !== 8'h30 || done !== 1'b0 || run !== 1'b1) begin bad++; $display("FAIL top_branch pc=%h done=%b run=%b want 30/0/1", imem_addr, done, run); end
        finish_run();
    endtask

    task automatic test_same_cycle;
        lut_write(5'd2, 8'h10);
        do_start();
        tick();
        lut_wr_en = 1'b1; lut_wr_idx = 5'd2; lut_wr_data = 8'h40;
        branch_to(5'd2);
        lut_wr_en = 1'b0;
        total++; if (imem_addr !== 8'h10) begin bad++; $display("FAIL same_cycle_old got=%h want=10", imem_addr); end
        tick();
        total++; if (imem_addr !== 8'h11) begin bad++; $display("FAIL same_cycle_inc got=%h want=11", imem_addr); end
        branch_to(5'd2);
        total++; if (imem_addr !== 8'h40) begin bad++; $display("FAIL same_cycle_new got=%h want=40", imem_addr); end
        finish_run();
    endtask

    task automatic test_reset_mid;
        lut_write(5'd4, 8'h11);
        do_start();
        branch_to(5'd4);
        total++; if (imem_addr !== 8'h11 || run !== 1'b1) begin bad++; $display("FAIL mid_pre pc=%h run=%b want 11/1", imem_addr, run); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (run !== 1'b0 || imem_addr !== 8'h00 || cycle_count !== 32'd0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset run=%b pc=%h cyc=%0d done=%b want 0/00/0/0", run, imem_addr, cycle_count, done); end
        tick();
        total++; if (run !== 1'b0) begin bad++; $display("FAIL mid_idle run=%b want=0", run); end
        do_start();
        total++; if (run !== 1'b1 || imem_addr !== 8'h00) begin bad++; $display("FAIL mid_restart run=%b pc=%h want 1/00", run, imem_addr); end
        branch_to(5'd3);
        total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL lut_cleared got=%h want=00", imem_addr); end
        tick();
        total++; if (imem_addr !== 8'h01) begin bad++; $display("FAIL post_reset_inc got=%h want=01", imem_addr); end
        finish_run();
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; branch_taken = 1'b0; branch_idx = 5'd0; stall = 1'b0;
        lut_wr_en = 1'b0; lut_wr_idx = 5'd0; lut_wr_data = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 9'h001;
        test_reset();
        test_branch();
        test_timeout();
        test_halt();
        test_stall();
        test_wrap_end();
        test_same_cycle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
